// File: rtl/seq_subtractor_24bit_if.sv
// Operand/result handshake bundle for the multi-cycle subtractor.
// master drives operands and consumes results; slave is the subtractor.
interface seq_subtractor_24bit_if #(
    parameter int WIDTH = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/seq_subtractor_24bit.sv
// Multi-cycle subtractor: {bout, diff} = a - b - bin, CHUNK_W bits per cycle,
// LSB chunk first, with the inter-chunk borrow held in a register.
module seq_subtractor_24bit #(
    parameter int WIDTH   = 24,
    parameter int CHUNK_W = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    seq_subtractor_24bit_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               borrow_reg;
    logic [WIDTH-1:0]   diff_reg;
    logic               bout_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;

    logic [CHUNK_W:0]   chunk_sub;
    logic [CHUNK_W-1:0] chunk_diff;
    logic               chunk_borrow;
    logic [WIDTH-1:0]   diff_next;

    // Operands shift down one chunk per RUN cycle so the current chunk is
    // always the low bits; diff fills from the top, landing in place after
    // NCHUNK shifts. Equivalent to indexing chunk cnt directly.
    always_comb begin
        chunk_sub    = {1'b0, a_sh[CHUNK_W-1:0]}
                     - {1'b0, b_sh[CHUNK_W-1:0]}
                     - {{CHUNK_W{1'b0}}, borrow_reg};
        chunk_diff   = chunk_sub[CHUNK_W-1:0];
        chunk_borrow = chunk_sub[CHUNK_W];
        diff_next    = (diff_reg >> CHUNK_W)
                     | (WIDTH'(chunk_diff) << (WIDTH - CHUNK_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            a_sh          <= '0;
            b_sh          <= '0;
            borrow_reg    <= 1'b0;
            diff_reg      <= '0;
            bout_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        a_sh         <= bus.a;
                        b_sh         <= bus.b;
                        borrow_reg   <= bus.bin;
                        cnt          <= '0;
                        in_ready_reg <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    a_sh       <= a_sh >> CHUNK_W;
                    b_sh       <= b_sh >> CHUNK_W;
                    borrow_reg <= chunk_borrow;
                    diff_reg   <= diff_next;
                    cnt        <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        bout_reg      <= chunk_borrow;
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.diff      = diff_reg;
    assign bus.bout      = bout_reg;
endmodule

// File: tb/tb_seq_subtractor_24bit.sv
// Self-checking bench for seq_subtractor_24bit against an arithmetic reference.
module tb_seq_subtractor_24bit;
    localparam int WIDTH   = 24;
    localparam int CHUNK_W = 4;
    localparam int NCHUNK  = WIDTH / CHUNK_W;
    localparam int LATENCY = NCHUNK + 1;  // edges to out_valid, accept edge counted as 1
    localparam int PERIOD  = NCHUNK + 2;
    localparam int NB2B    = 200;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_subtractor_24bit_if #(.WIDTH(WIDTH)) bus ();

    seq_subtractor_24bit #(.WIDTH(WIDTH), .CHUNK_W(CHUNK_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic bin);
        return {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    endfunction

    // Presents operands until accepted, then scrambles them; returns at the
    // negedge after the accept edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic bin, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = WIDTH'($urandom);
        bus.b = WIDTH'($urandom);
        bus.bin = 1'($urandom);
    endtask

    task automatic wait_result(output int edges, output bit ok);
        edges = 1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic test_single(input string name, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic bin,
                               input bit check_lat);
        bit ok_in, ok_out;
        int edges;
        logic [WIDTH:0] exp;
        exp = ref_sub(a, b, bin);
        bus.out_ready = 1'b1;
        start_op(a, b, bin, ok_in);
        wait_result(edges, ok_out);
        checks++;
        if (!(ok_in && ok_out)) begin
            errors++;
            $display("FAIL %s timeout: accepted=%0d result=%0d required 1/1", name, ok_in, ok_out);
        end
        checks++;
        if (bus.diff !== exp[WIDTH-1:0]) begin
            errors++;
            $display("FAIL %s diff: got %0d required %0d", name, bus.diff, exp[WIDTH-1:0]);
        end
        checks++;
        if (bus.bout !== exp[WIDTH]) begin
            errors++;
            $display("FAIL %s bout: got %0d required %0d", name, bus.bout, exp[WIDTH]);
        end
        if (check_lat) begin
            checks++;
            if (edges != LATENCY) begin
                errors++;
                $display("FAIL %s latency: got %0d edges required %0d", name, edges, LATENCY);
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s consume: out_valid=%0d in_ready=%0d required 0/1",
                     name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        #12;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== '0 || bus.bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%0d out_valid=%0d diff=%0d bout=%0d required 1/0/0/0",
                     bus.in_ready, bus.out_valid, bus.diff, bus.bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: in_ready=%0d out_valid=%0d required 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_vectors();
        test_single("basic", 24'd98, 24'd48, 1'b0, 1'b1);
        test_single("underflow", 24'd48, 24'd98, 1'b0, 1'b1);
        test_single("zero_minus_bin", 24'd0, 24'd0, 1'b1, 1'b0);
        test_single("borrow_in_a", 24'd34849, 24'd538, 1'b1, 1'b0);
        test_single("borrow_in_b", 24'd2746128, 24'd2141202, 1'b1, 1'b0);
        test_single("max_minus_max", '1, '1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            test_single("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
    endtask

    task automatic test_backpressure();
        bit ok_in, ok_out;
        int edges;
        logic [WIDTH:0] exp;
        logic [WIDTH-1:0] a, b;
        logic bin;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        bin = 1'($urandom);
        exp = ref_sub(a, b, bin);
        bus.out_ready = 1'b0;
        start_op(a, b, bin, ok_in);
        wait_result(edges, ok_out);
        checks++;
        if (!(ok_in && ok_out)) begin
            errors++;
            $display("FAIL bp timeout: accepted=%0d result=%0d required 1/1", ok_in, ok_out);
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a = WIDTH'($urandom);
            bus.b = WIDTH'($urandom);
            bus.bin = 1'($urandom);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.diff !== exp[WIDTH-1:0] || bus.bout !== exp[WIDTH]) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: out_valid=%0d in_ready=%0d diff=%0d bout=%0d required 1/0/%0d/%0d",
                         i, bus.out_valid, bus.in_ready, bus.diff, bus.bout, exp[WIDTH-1:0], exp[WIDTH]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.diff !== exp[WIDTH-1:0]) begin
            errors++;
            $display("FAIL bp_final: out_valid=%0d diff=%0d required 1/%0d",
                     bus.out_valid, bus.diff, exp[WIDTH-1:0]);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%0d in_ready=%0d required 0/1",
                     bus.out_valid, bus.in_ready);
        end
        test_single("after_bp", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
    endtask

    task automatic test_reset_mid_run();
        bit ok_in;
        bus.out_ready = 1'b1;
        start_op(24'hF0F0F0, 24'h0F0F0F, 1'b1, ok_in);
        // now in the 1st RUN cycle; advance to the 3rd
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (!ok_in || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_busy: accepted=%0d in_ready=%0d required 1/0", ok_in, bus.in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.diff !== '0 || bus.bout !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_reset: out_valid=%0d diff=%0d bout=%0d in_ready=%0d required 0/0/0/1",
                     bus.out_valid, bus.diff, bus.bout, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_no_result: out_valid=%0d required 0", bus.out_valid);
        end
        test_single("after_reset", 24'd5, 24'd7, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH:0] exp_q[$];
        logic [WIDTH:0] exp;
        int accepted = 0;
        int results = 0;
        int last_cyc = -1;
        int cyc = 0;
        int budget = NB2B * PERIOD + 100;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        while (results < NB2B && cyc < budget) begin
            if (bus.out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b unexpected result: diff=%0d with no pending op", bus.diff);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.diff !== exp[WIDTH-1:0] || bus.bout !== exp[WIDTH]) begin
                        errors++;
                        $display("FAIL b2b result %0d: diff=%0d bout=%0d required %0d/%0d",
                                 results, bus.diff, bus.bout, exp[WIDTH-1:0], exp[WIDTH]);
                    end
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc != PERIOD) begin
                        errors++;
                        $display("FAIL b2b interval: got %0d cycles required %0d", cyc - last_cyc, PERIOD);
                    end
                end
                last_cyc = cyc;
                results++;
            end
            if (bus.in_valid) begin
                case ($urandom_range(0, 7))
                    0: begin bus.a = '0; bus.b = WIDTH'($urandom); end
                    1: begin bus.a = WIDTH'($urandom); bus.b = '1; end
                    default: begin bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); end
                endcase
                bus.bin = 1'($urandom);
                if (bus.in_ready) begin
                    exp_q.push_back(ref_sub(bus.a, bus.b, bus.bin));
                    accepted++;
                    if (accepted == NB2B) begin
                        @(posedge clk);
                        @(negedge clk);
                        cyc++;
                        bus.in_valid = 1'b0;
                        continue;
                    end
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (results != NB2B) begin
            errors++;
            $display("FAIL b2b count: got %0d results required %0d", results, NB2B);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
